// File: rtl/status_wb_arbiter.sv
// Status writeback arbiter: shares the register-file write port between the
// normal writeback path and queued overflow status codes.
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   ovf_valid/ovf_code      overflow event and its status code (code 0 ignored)
//   ovf_ready               status FIFO not full (from registered state)
//   wb_valid/wb_rd/wb_data  normal writeback request
//   wb_stall                writeback not granted this cycle (combinational)
//   rf_we/rf_wr_addr/rf_wr_data  registered register-file write port
//   exc_pending             status FIFO non-empty (registered)
module status_wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MAX_DEFER  = 3,
  parameter int unsigned STATUS_REG = 30
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ovf_valid,
  input  logic [31:0] ovf_code,
  output logic        ovf_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        exc_pending
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DC_RAW = $clog2(MAX_DEFER + 1);
  localparam int unsigned DC_W   = (DC_RAW < 2) ? 2 : DC_RAW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEFER = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DC_W-1:0]   defer_cnt, defer_nxt;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;

  logic empty, full, push, exc_grant, wb_grant, flush;

  // Grant and FIFO control, all derived from registered state
  always_comb begin
    empty     = (count == CNT_W'(0));
    full      = (count == CNT_W'(DEPTH));
    ovf_ready = !full;
    push      = ovf_valid && ovf_ready && (ovf_code != 32'd0);
    exc_grant = !empty && (!wb_valid || (state == FORCE));
    wb_grant  = wb_valid && !exc_grant;
    wb_stall  = wb_valid && exc_grant;
    flush     = wb_grant && (wb_rd == 5'(STATUS_REG));
  end

  // Occupancy after this cycle; a flush keeps only a same-cycle push
  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = push ? CNT_W'(1) : CNT_W'(0);
    else
      count_nxt = count + CNT_W'(push) - CNT_W'(exc_grant);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      defer_cnt <= '0;
    end else begin
      state     <= state_nxt;
      defer_cnt <= defer_nxt;
    end
  end

  // Next-state logic for the starvation bound
  always_comb begin
    state_nxt = state;
    defer_nxt = defer_cnt;
    case (state)
      IDLE: begin
        if (push) begin
          state_nxt = DEFER;
          defer_nxt = '0;
        end
      end
      DEFER: begin
        if (flush) begin
          defer_nxt = '0;
          state_nxt = push ? DEFER : IDLE;
        end else if (exc_grant) begin
          defer_nxt = '0;
          state_nxt = (count_nxt != CNT_W'(0)) ? DEFER : IDLE;
        end else if (wb_grant && !empty) begin
          if (defer_cnt != DC_W'(MAX_DEFER))
            defer_nxt = defer_cnt + DC_W'(1);
          if (defer_nxt == DC_W'(MAX_DEFER))
            state_nxt = FORCE;
        end
      end
      FORCE: begin
        defer_nxt = '0;
        state_nxt = (count_nxt != CNT_W'(0)) ? DEFER : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        defer_nxt = '0;
      end
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      exc_pending <= 1'b0;
    end else begin
      count       <= count_nxt;
      exc_pending <= (count_nxt != CNT_W'(0));
      if (flush) begin
        // Discard queue by snapping head to tail
        rd_ptr <= wr_ptr;
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
      end else begin
        if (exc_grant)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // FIFO storage (contents need no reset; occupancy guards them)
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= ovf_code;
  end

  // Registered register-file write port
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rf_we      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else if (exc_grant) begin
      rf_we      <= 1'b1;
      rf_wr_addr <= 5'(STATUS_REG);
      rf_wr_data <= mem[rd_ptr];
    end else if (wb_grant) begin
      rf_we      <= (wb_rd != 5'd0);
      rf_wr_addr <= wb_rd;
      rf_wr_data <= wb_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_status_wb_arbiter.sv
module tb_status_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ovf_valid;
  logic [31:0] ovf_code;
  logic        ovf_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        exc_pending;

  int checks   = 0;
  int failures = 0;

  status_wb_arbiter #(.DEPTH(2), .MAX_DEFER(3), .STATUS_REG(30)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ovf_valid   (ovf_valid),
    .ovf_code    (ovf_code),
    .ovf_ready   (ovf_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_stall    (wb_stall),
    .rf_we       (rf_we),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .exc_pending (exc_pending)
  );

  always #5 clock = ~clock;

  // Advance one cycle; registered outputs are stable 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ovf_valid = 1'b0;
    ovf_code  = 32'd0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", rf_we); end
    checks++; if (rf_wr_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rf_wr_addr); end
    checks++; if (rf_wr_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", rf_wr_data); end
    checks++; if (exc_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%0h exp=0", exc_pending); end
    checks++; if (ovf_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", ovf_ready); end
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", wb_stall); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    ovf_valid = 1'b1; ovf_code = 32'd2;
    tick();
    ovf_valid = 1'b0; ovf_code = 32'd0;
    checks++; if (exc_pending !== 1'b1) begin failures++; $display("FAIL single_pending got=%0h exp=1", exc_pending); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_no_pass got=%0h exp=0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL single_we got=%0h exp=1", rf_we); end
    checks++; if (rf_wr_addr !== 5'd30) begin failures++; $display("FAIL single_addr got=%0d exp=30", rf_wr_addr); end
    checks++; if (rf_wr_data !== 32'd2) begin failures++; $display("FAIL single_data got=%0h exp=2", rf_wr_data); end
    checks++; if (exc_pending !== 1'b0) begin failures++; $display("FAIL single_drained got=%0h exp=0", exc_pending); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_idle_we got=%0h exp=0", rf_we); end
    checks++; if (rf_wr_addr !== 5'd30 || rf_wr_data !== 32'd2) begin failures++; $display("FAIL single_hold got=%0d/%0h exp=30/2", rf_wr_addr, rf_wr_data); end
  endtask

  task automatic test_starvation();
    ovf_valid = 1'b1; ovf_code = 32'd1;
    tick();
    ovf_valid = 1'b0; ovf_code = 32'd0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL starve_stall%0d got=%0h exp=0", i, wb_stall); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'h55) begin failures++; $display("FAIL starve_wb%0d got=%0h/%0d/%0h exp=1/5/55", i, rf_we, rf_wr_addr, rf_wr_data); end
    end
    #1;
    checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL force_stall got=%0h exp=1", wb_stall); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd30 || rf_wr_data !== 32'd1) begin failures++; $display("FAIL force_write got=%0h/%0d/%0h exp=1/30/1", rf_we, rf_wr_addr, rf_wr_data); end
    checks++; if (exc_pending !== 1'b0) begin failures++; $display("FAIL force_pending got=%0h exp=0", exc_pending); end
    #1;
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL held_stall got=%0h exp=0", wb_stall); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'h55) begin failures++; $display("FAIL held_wb got=%0h/%0d/%0h exp=1/5/55", rf_we, rf_wr_addr, rf_wr_data); end
    idle_inputs();
    tick();
  endtask

  task automatic test_full();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    ovf_valid = 1'b1; ovf_code = 32'd1;
    tick();
    ovf_code = 32'd3;
    tick();
    // FIFO now full; third code offered while writeback drops away
    wb_valid = 1'b0;
    ovf_code = 32'd5;
    #1;
    checks++; if (ovf_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0h exp=0", ovf_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd30 || rf_wr_data !== 32'd1) begin failures++; $display("FAIL drain0 got=%0h/%0d/%0h exp=1/30/1", rf_we, rf_wr_addr, rf_wr_data); end
    checks++; if (ovf_ready !== 1'b1) begin failures++; $display("FAIL drain0_ready got=%0h exp=1", ovf_ready); end
    tick();
    ovf_valid = 1'b0; ovf_code = 32'd0;
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd30 || rf_wr_data !== 32'd3) begin failures++; $display("FAIL drain1 got=%0h/%0d/%0h exp=1/30/3", rf_we, rf_wr_addr, rf_wr_data); end
    checks++; if (exc_pending !== 1'b1) begin failures++; $display("FAIL drain1_pending got=%0h exp=1", exc_pending); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd30 || rf_wr_data !== 32'd5) begin failures++; $display("FAIL drain2 got=%0h/%0d/%0h exp=1/30/5", rf_we, rf_wr_addr, rf_wr_data); end
    checks++; if (exc_pending !== 1'b0) begin failures++; $display("FAIL drain2_pending got=%0h exp=0", exc_pending); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL drain_extra got=%0h exp=0", rf_we); end
  endtask

  task automatic test_flush();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    ovf_valid = 1'b1; ovf_code = 32'd3;
    tick();
    ovf_valid = 1'b0; ovf_code = 32'd0;
    wb_rd = 5'd30; wb_data = 32'hABCD;
    #1;
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0h exp=0", wb_stall); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd30 || rf_wr_data !== 32'hABCD) begin failures++; $display("FAIL flush_write got=%0h/%0d/%0h exp=1/30/abcd", rf_we, rf_wr_addr, rf_wr_data); end
    checks++; if (exc_pending !== 1'b0) begin failures++; $display("FAIL flush_pending got=%0h exp=0", exc_pending); end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL flush_stale%0d got=%0h exp=0", i, rf_we); end
    end
  endtask

  task automatic test_rd_zero();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rd0_we got=%0h exp=0", rf_we); end
    checks++; if (rf_wr_addr !== 5'd0 || rf_wr_data !== 32'h1234) begin failures++; $display("FAIL rd0_bus got=%0d/%0h exp=0/1234", rf_wr_addr, rf_wr_data); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midop();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    ovf_valid = 1'b1; ovf_code = 32'd1;
    tick();
    ovf_code = 32'd2;
    tick();
    checks++; if (exc_pending !== 1'b1 || ovf_ready !== 1'b0) begin failures++; $display("FAIL mid_queued got=%0h/%0h exp=1/0", exc_pending, ovf_ready); end
    idle_inputs();
    reset_n = 1'b0;
    tick();
    checks++; if (exc_pending !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0h/%0h exp=0/0", exc_pending, rf_we); end
    checks++; if (ovf_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0h exp=1", ovf_ready); end
    reset_n = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0 || exc_pending !== 1'b0) begin failures++; $display("FAIL mid_after got=%0h/%0h exp=0/0", rf_we, exc_pending); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_starvation();
    test_full();
    test_flush();
    test_rd_zero();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
